// File: rtl/note_envelope_pwm_pkg.sv
// Shared types and constants for the note envelope / PWM audio output stage.
package note_envelope_pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam int ENV_W = 8;
    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    localparam int DEF_ATTACK_STEP   = 16;
    localparam int DEF_DECAY_STEP    = 4;
    localparam int DEF_SUSTAIN_LEVEL = 160;
    localparam int DEF_RELEASE_STEP  = 2;

endpackage

// File: rtl/note_envelope_pwm_pwm_modulator.sv
// Free-running PWM: the duty word is captured once per period so a mid-period
// duty change never truncates or stretches the current pulse.
module pwm_modulator #(
    parameter int PWM_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwmOut
);

    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_p0;

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty_p0 <= '0;
            pwmOut  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == CNT_LAST) begin
                duty_p0 <= duty;
            end
            // Output stage: compare result registered to keep the pin glitch-free.
            pwmOut <= (pwm_cnt < duty_p0);
        end
    end

endmodule

// File: rtl/note_envelope_pwm.sv
// Tick-driven ADSR envelope with volume scaling, feeding a 1-bit PWM audio pin.
module note_envelope_pwm
    import note_envelope_pwm_pkg::*;
#(
    parameter int ENV_TICK_DIV  = 100_000,
    parameter int PWM_BITS      = 8,
    parameter int ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter int DECAY_STEP    = DEF_DECAY_STEP,
    parameter int SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
    parameter int RELEASE_STEP  = DEF_RELEASE_STEP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             toneIn,
    input  logic             noteStart,
    input  logic             noteActive,
    input  logic [3:0]       volume,
    output logic             pwmOut,
    output logic             aud_sd,
    output logic [ENV_W-1:0] envLevel
);

    localparam int TW = $clog2(ENV_TICK_DIV);
    localparam logic [TW-1:0]    TICK_LAST   = TW'(ENV_TICK_DIV - 1);
    localparam logic [ENV_W-1:0] ATTACK_INC  = ENV_W'(ATTACK_STEP);
    localparam logic [ENV_W-1:0] DECAY_DEC   = ENV_W'(DECAY_STEP);
    localparam logic [ENV_W-1:0] RELEASE_DEC = ENV_W'(RELEASE_STEP);
    localparam logic [ENV_W-1:0] SUSTAIN_LVL = ENV_W'(SUSTAIN_LEVEL);

    function automatic logic [ENV_W-1:0] sat_add(input logic [ENV_W-1:0] a,
                                                 input logic [ENV_W-1:0] b);
        logic [ENV_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ENV_W] ? ENV_MAX : sum[ENV_W-1:0];
    endfunction

    // Subtract with a lower clamp; done wide and signed so nothing wraps.
    function automatic logic [ENV_W-1:0] sub_floor(input logic [ENV_W-1:0] a,
                                                   input logic [ENV_W-1:0] b,
                                                   input logic [ENV_W-1:0] floor_lvl);
        logic signed [ENV_W+1:0] diff;
        diff = $signed({2'b00, a}) - $signed({2'b00, b});
        if (diff <= $signed({2'b00, floor_lvl})) begin
            return floor_lvl;
        end
        return diff[ENV_W-1:0];
    endfunction

    logic [TW-1:0]    tick_cnt;
    logic             tick;
    env_state_t       state;
    env_state_t       state_next;
    logic [ENV_W-1:0] env_next;
    logic             tone_p0;
    logic [4:0]       vol_scale;
    logic [11:0]      prod;
    logic [ENV_W-1:0] amp;
    logic [PWM_BITS-1:0] duty;

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        state_next = state;
        env_next   = envLevel;
        case (state)
            ST_IDLE: env_next = '0;
            ST_ATTACK: begin
                if (tick) begin
                    env_next = sat_add(envLevel, ATTACK_INC);
                    if (env_next == ENV_MAX) state_next = ST_DECAY;
                end
            end
            ST_DECAY: begin
                if (tick) begin
                    env_next = sub_floor(envLevel, DECAY_DEC, SUSTAIN_LVL);
                    if (env_next == SUSTAIN_LVL) state_next = ST_SUSTAIN;
                end
            end
            ST_SUSTAIN: ;
            ST_RELEASE: begin
                if (tick) begin
                    env_next = sub_floor(envLevel, RELEASE_DEC, '0);
                    if (env_next == '0) state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                env_next   = '0;
            end
        endcase
        // Note boundaries override the tick-driven transition; the step above
        // was still computed in the old state.
        if (noteStart) begin
            state_next = ST_ATTACK;
        end else if (!noteActive && (state == ST_ATTACK || state == ST_DECAY ||
                                     state == ST_SUSTAIN)) begin
            state_next = ST_RELEASE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
            state    <= ST_IDLE;
            envLevel <= '0;
            tone_p0  <= 1'b0;
            aud_sd   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            state    <= state_next;
            envLevel <= env_next;
            tone_p0  <= toneIn;
            aud_sd   <= (state != ST_IDLE);
        end
    end

    // volume+1 in 1..16, so the product of an 8-bit level never exceeds 12 bits.
    assign vol_scale = {1'b0, volume} + 5'd1;
    assign prod      = {4'b0000, envLevel} * {7'b0000000, vol_scale};
    assign amp       = ENV_W'(prod >> 4);
    assign duty      = tone_p0 ? PWM_BITS'(amp >> (ENV_W - PWM_BITS)) : '0;

    pwm_modulator #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clock (clock),
        .reset (reset),
        .duty  (duty),
        .pwmOut(pwmOut)
    );

endmodule
